// File: rtl/irrigation_scheduler.sv
// Multi-zone irrigation scheduler: round-robin grants one dry zone at a time from a shared
// water box, runs its valve for a bounded time, then enforces a cooldown before the next grant.
module irrigation_scheduler #(
  parameter int N_ZONES     = 4,
  parameter int RUN_CYCLES  = 16,
  parameter int COOL_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       air_umidity,
  input  logic                       temperature,
  input  logic [N_ZONES-1:0]         soil_umidity,
  input  logic [1:0]                 water_box,
  output logic [N_ZONES-1:0]         sprinkler,
  output logic [N_ZONES-1:0]         drip,
  output logic                       specific,
  output logic                       busy,
  output logic [$clog2(N_ZONES)-1:0] active_zone,
  output logic                       fault
);

  localparam int ZW      = $clog2(N_ZONES);
  localparam int CNT_MAX = (RUN_CYCLES > COOL_CYCLES) ? RUN_CYCLES : COOL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_RUN,
    S_COOL
  } state_e;

  state_e               state_q, state_d;
  logic [ZW-1:0]        rr_q, rr_d;
  logic [ZW-1:0]        zone_q, zone_d;
  logic                 meth_spr_q, meth_spr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 fault_q, fault_d;
  logic [N_ZONES-1:0]   spk_q, spk_d;
  logic [N_ZONES-1:0]   drip_q, drip_d;
  logic                 specific_q;

  logic                 w_empty, w_reduced, w_full;
  logic [N_ZONES-1:0]   dry;
  logic                 any_dry;
  logic                 pick_found;
  logic [ZW-1:0]        pick_zone;
  logic [ZW-1:0]        cand;
  int                   pick_idx;
  logic [ZW-1:0]        rr_after;
  logic [N_ZONES-1:0]   onehot;
  logic                 method_spr;
  logic                 run_stop;

  assign w_empty    = (water_box == 2'b00);
  assign w_reduced  = (water_box == 2'b10) || (water_box == 2'b01);
  assign w_full     = (water_box == 2'b11);
  assign dry        = ~soil_umidity;
  assign any_dry    = |dry;
  assign method_spr = ~air_umidity | (~temperature & w_reduced);
  assign rr_after   = (zone_q == ZW'(N_ZONES - 1)) ? '0 : zone_q + ZW'(1);
  assign run_stop   = soil_umidity[zone_q] | ~enable | w_empty;

  // Scan from the highest offset down so the dry zone closest to the pointer wins last.
  always_comb begin
    pick_found = 1'b0;
    pick_zone  = '0;
    pick_idx   = 0;
    cand       = '0;
    for (int i = N_ZONES - 1; i >= 0; i--) begin
      pick_idx = int'(rr_q) + i;
      if (pick_idx >= N_ZONES) pick_idx = pick_idx - N_ZONES;
      cand = ZW'(pick_idx);
      if (dry[cand]) begin
        pick_found = 1'b1;
        pick_zone  = cand;
      end
    end
  end

  always_comb begin
    onehot            = '0;
    onehot[pick_zone] = 1'b1;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    zone_d     = zone_q;
    meth_spr_d = meth_spr_q;
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    spk_d      = spk_q;
    drip_d     = drip_q;

    unique case (state_q)
      S_IDLE: begin
        if (w_full) fault_d = 1'b0;
        if (enable && !w_empty && any_dry && (!fault_q || w_full)) state_d = S_SELECT;
      end

      S_SELECT: begin
        if (enable && !w_empty && pick_found) begin
          zone_d     = pick_zone;
          meth_spr_d = method_spr;
          cnt_d      = CW'(RUN_CYCLES - 1);
          spk_d      = method_spr ? onehot : '0;
          drip_d     = method_spr ? '0 : onehot;
          state_d    = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (run_stop || (cnt_q == '0)) begin
          state_d = S_COOL;
          spk_d   = '0;
          drip_d  = '0;
          rr_d    = rr_after;
          cnt_d   = CW'(COOL_CYCLES - 1);
          if (w_empty) fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_COOL: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      zone_q     <= '0;
      meth_spr_q <= 1'b0;
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      spk_q      <= '0;
      drip_q     <= '0;
      specific_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      zone_q     <= zone_d;
      meth_spr_q <= meth_spr_d;
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      spk_q      <= spk_d;
      drip_q     <= drip_d;
      specific_q <= air_umidity & ~temperature;
    end
  end

  assign sprinkler   = spk_q;
  assign drip        = drip_q;
  assign specific    = specific_q;
  assign busy        = (state_q != S_IDLE);
  assign active_zone = zone_q;
  assign fault       = fault_q;

endmodule
